// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the EX-stage divide controller:
//   - ALUOP codes that request a divide (signed DIV, unsigned DIVU)
//   - FSM state encodings
//   - divider handshake constants (start/stop, ready/not-ready)
//   - small decode helpers used by the controller
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

    // EX-stage operation codes
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Divider handshake levels
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ABORT = 2'b11
    } div_state_e;

    // True for either divide flavour
    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    // True only for the signed divide
    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Sequencing FSM that sits between the EX stage and the multi-cycle divider.
// It captures the operands of a DIV/DIVU, holds them steady towards the
// divider while it works, stalls the pipeline meanwhile, and writes the
// {remainder, quotient} result to HI/LO for one cycle when the divider is
// ready. A pipeline flush or a watchdog expiry cancels the operation and
// parks the FSM in ABORT for a few cycles so the divider can leave its end
// state before any new request is accepted.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   aluop_i[7:0]   in   EX-stage operation code
//   reg1_i[31:0]   in   dividend
//   reg2_i[31:0]   in   divisor
//   flush_i        in   pipeline flush
//   div_ready_i    in   divider result ready
//   div_result_i   in   divider result {remainder, quotient}
//   div_start_o    out  divider start (1) / stop (0)
//   div_annul_o    out  divider cancel
//   signed_div_o   out  1 = signed divide
//   div_opdata1_o  out  dividend held to the divider
//   div_opdata2_o  out  divisor held to the divider
//   stallreq_o     out  pipeline stall request
//   hilo_we_o      out  HI/LO write enable (one-cycle pulse)
//   hi_o / lo_o    out  remainder / quotient
//   timeout_o      out  one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = 40,  // max BUSY cycles waiting for ready
    parameter int ABORT_CYCLES = 2    // cycles spent in ABORT (>= 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        signed_div_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int AB_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    // Watchdog value seen during the last permitted BUSY cycle: the counter
    // is cleared on BUSY entry, so BUSY cycle N shows N-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [AB_W-1:0] AB_LAST = AB_W'(ABORT_CYCLES - 1);

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    div_state_e        r_state;
    logic [WD_W-1:0]   r_wdog;
    logic [AB_W-1:0]   r_abort_cnt;
    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic              r_signed;
    logic [63:0]       r_result;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic w_div_req;     // new divide request seen in IDLE
    logic w_busy;
    logic w_busy_flush;  // flush wins over ready and watchdog
    logic w_busy_ready;
    logic w_busy_tmo;    // watchdog expiry with no ready in the same cycle
    logic w_busy_abort;

    assign w_div_req    = is_div_op(aluop_i) && !flush_i;
    assign w_busy       = (r_state == ST_BUSY);
    assign w_busy_flush = w_busy && flush_i;
    assign w_busy_ready = w_busy && !flush_i && (div_ready_i == DIV_RESULT_READY);
    assign w_busy_tmo   = w_busy && !flush_i && (div_ready_i == DIV_RESULT_NOT_READY)
                          && (r_wdog == WD_LAST);
    assign w_busy_abort = w_busy_flush || w_busy_tmo;

    // -----------------------------------------------------------------------
    // FSM and data capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wdog      <= '0;
            r_abort_cnt <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_signed    <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // div_ready_i is deliberately not looked at here.
                    if (w_div_req) begin
                        r_op1    <= reg1_i;
                        r_op2    <= reg2_i;
                        r_signed <= is_signed_op(aluop_i);
                        r_wdog   <= '0;
                        r_state  <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (w_busy_abort) begin
                        r_abort_cnt <= '0;
                        r_state     <= ST_ABORT;
                    end else if (w_busy_ready) begin
                        r_result <= div_result_i;
                        r_state  <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                ST_ABORT: begin
                    // Start is held low here so the divider drops back to its
                    // idle state; a ready left over from the cancelled
                    // operation is never sampled.
                    if (r_abort_cnt == AB_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_abort_cnt <= r_abort_cnt + AB_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control outputs: decoded from state plus current inputs so the stall
    // appears in the same cycle the divide is detected. Forced low while rst
    // is high so nothing leaks out during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        div_start_o = DIV_STOP;
        div_annul_o = 1'b0;
        stallreq_o  = 1'b0;
        hilo_we_o   = 1'b0;
        timeout_o   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    stallreq_o = w_div_req;
                end
                ST_BUSY: begin
                    stallreq_o = 1'b1;
                    if (w_busy_abort) begin
                        div_annul_o = 1'b1;
                        div_start_o = DIV_STOP;
                    end else begin
                        div_start_o = DIV_START;
                    end
                    timeout_o = w_busy_tmo;
                end
                ST_DONE: begin
                    // A flush landing on the write cycle kills the write.
                    hilo_we_o = !flush_i;
                end
                ST_ABORT: begin
                    div_start_o = DIV_STOP;
                end
                default: begin
                    div_start_o = DIV_STOP;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data outputs come straight from registers
    // -----------------------------------------------------------------------
    assign signed_div_o  = r_signed;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign hi_o          = r_result[63:32];
    assign lo_o          = r_result[31:0];

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Directed bench for div_ctrl. A small behavioural divider answers the
// controller; expected HI/LO values are hand-computed constants pushed into
// a scoreboard when each divide is issued, and a negedge monitor pops and
// compares whenever hilo_we_o is seen.
// ---------------------------------------------------------------------------
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        flush;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_start_o;
    logic        div_annul_o;
    logic        signed_div_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    div_ctrl #(.TIMEOUT(TMO), .ABORT_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop),
        .reg1_i       (reg1),
        .reg2_i       (reg2),
        .flush_i      (flush),
        .div_ready_i  (div_ready),
        .div_result_i (div_result),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .signed_div_o (signed_div_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .stallreq_o   (stallreq_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .timeout_o    (timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural divider ----------------
    int          lat = 0;        // BUSY cycles until ready; 0 = never
    int          stub_cnt = 0;
    logic        model_ready = 1'b0;
    logic        force_ready = 1'b0;
    logic [63:0] model_res = '0;

    assign div_ready  = model_ready | force_ready;
    assign div_result = model_res;

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (rst || div_start_o !== 1'b1) begin
            stub_cnt    = 0;
            model_ready = 1'b0;
        end else begin
            stub_cnt++;
            if (lat > 0 && stub_cnt >= lat) begin
                model_ready = 1'b1;
                model_res   = div_model(div_opdata1_o, div_opdata2_o, signed_div_o);
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    logic [63:0] sb_q[$];
    logic [63:0] sb_e;
    logic [31:0] exp_op1 = '0;
    logic [31:0] exp_op2 = '0;
    logic        exp_sgn = 1'b0;
    logic        exp_valid = 1'b0;
    int          n_timeout = 0;
    int          n_annul = 0;

    always @(negedge clk) begin
        if (hilo_we_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got hi=%0h lo=%0h want no write (t=%0t)",
                         hi_o, lo_o, $time);
            end else begin
                sb_e = sb_q.pop_front();
                chk("hi_o", 64'(hi_o), 64'(sb_e[63:32]));
                chk("lo_o", 64'(lo_o), 64'(sb_e[31:0]));
                $display("write hi=%h lo=%h", hi_o, lo_o);
            end
        end
        if (div_start_o === 1'b1 && exp_valid) begin
            chk("busy_opdata1", 64'(div_opdata1_o), 64'(exp_op1));
            chk("busy_opdata2", 64'(div_opdata2_o), 64'(exp_op2));
            chk("busy_signed",  64'(signed_div_o),  64'(exp_sgn));
        end
        if (timeout_o === 1'b1)   n_timeout++;
        if (div_annul_o === 1'b1) n_annul++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int l, input logic esg);
        force_ready = 1'b0;
        lat     = l;
        aluop   = op;
        reg1    = a;
        reg2    = b;
        exp_op1 = a;
        exp_op2 = b;
        exp_sgn = esg;
        exp_valid = 1'b1;
    endtask

    // Drives a divide in the next cycle (expected to be IDLE) and waits for DONE.
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int l, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic esg);
        bit done;
        int busy_n;
        @(posedge clk); #1;
        issue(op, a, b, l, esg);
        sb_q.push_back({ehi, elo});
        #1;
        chk({name, "_stall_detect"}, 64'(stallreq_o), 64'd1);
        chk({name, "_start_idle"},   64'(div_start_o), 64'd0);
        @(posedge clk); #1;
        // operands must now come from the latched copy
        aluop = EXE_NOP_OP;
        reg1  = 32'hDEAD_BEEF;
        reg2  = 32'h0000_1234;
        done = 0;
        busy_n = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (hilo_we_o === 1'b1) done = 1;
            else begin
                busy_n++;
                chk({name, "_stall_busy"}, 64'(stallreq_o), 64'd1);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_no_done: got no hilo_we_o within 200 cycles want a write", name);
        end else begin
            chk({name, "_stall_done"}, 64'(stallreq_o), 64'd0);
            chk({name, "_start_done"}, 64'(div_start_o), 64'd0);
            chk({name, "_busy_len"},   64'(busy_n), 64'(l));
        end
        $display("op %s a=%h b=%h busy=%0d", name, a, b, busy_n);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_start"},   64'(div_start_o),   64'd0);
        chk({name, "_annul"},   64'(div_annul_o),   64'd0);
        chk({name, "_signed"},  64'(signed_div_o),  64'd0);
        chk({name, "_op1"},     64'(div_opdata1_o), 64'd0);
        chk({name, "_op2"},     64'(div_opdata2_o), 64'd0);
        chk({name, "_stall"},   64'(stallreq_o),    64'd0);
        chk({name, "_we"},      64'(hilo_we_o),     64'd0);
        chk({name, "_hi"},      64'(hi_o),          64'd0);
        chk({name, "_lo"},      64'(lo_o),          64'd0);
        chk({name, "_timeout"}, 64'(timeout_o),     64'd0);
    endtask

    // ---------------- main sequence ----------------
    int early;

    initial begin
        rst = 1'b1; aluop = EXE_NOP_OP; reg1 = '0; reg2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_all_zero("reset");
        $display("reset released");

        // ready ignored in IDLE; flush blocks detection
        force_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            chk("idle_ready_we", 64'(hilo_we_o), 64'd0);
        end
        force_ready = 1'b0;
        aluop = EXE_DIVU_OP; reg1 = 32'd5; reg2 = 32'd1; flush = 1'b1;
        #1 chk("idle_flush_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #2;
        chk("idle_flush_start", 64'(div_start_o), 64'd0);
        flush = 1'b0; aluop = EXE_NOP_OP;

        // basic unsigned and signed divides
        run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 5, 32'd2, 32'd14, 1'b0);
        run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 6,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

        // flush in BUSY cycle 10
        @(posedge clk); #1;
        issue(EXE_DIVU_OP, 32'd1000, 32'd3, 20, 1'b0);
        #1 chk("flush_stall_detect", 64'(stallreq_o), 64'd1);
        @(posedge clk); #1;
        aluop = EXE_NOP_OP;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        #1;
        chk("flush_annul",   64'(div_annul_o), 64'd1);
        chk("flush_start",   64'(div_start_o), 64'd0);
        chk("flush_we",      64'(hilo_we_o),   64'd0);
        chk("flush_timeout", 64'(timeout_o),   64'd0);
        @(posedge clk); #1;
        flush = 1'b0; force_ready = 1'b1;
        aluop = EXE_DIVU_OP; reg1 = 32'd9; reg2 = 32'd3;
        for (int k = 1; k <= 2; k++) begin
            #1;
            chk("abort_annul", 64'(div_annul_o), 64'd0);
            chk("abort_start", 64'(div_start_o), 64'd0);
            chk("abort_stall", 64'(stallreq_o),  64'd0);
            if (k < 2) begin @(posedge clk); #1; end
        end
        run_div("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, 4, 32'd0, 32'd3, 1'b0);

        // watchdog: divider never answers
        @(posedge clk); #1;
        issue(EXE_DIVU_OP, 32'd77, 32'd5, 0, 1'b0);
        #1 chk("tmo_stall_detect", 64'(stallreq_o), 64'd1);
        @(posedge clk); #1;
        aluop = EXE_NOP_OP;
        early = 0;
        for (int k = 1; k < TMO; k++) begin
            if (timeout_o !== 1'b0 || div_annul_o !== 1'b0) early++;
            @(posedge clk); #1;
        end
        chk("tmo_early",   64'(early), 64'd0);
        chk("tmo_pulse",   64'(timeout_o),   64'd1);
        chk("tmo_annul",   64'(div_annul_o), 64'd1);
        chk("tmo_start",   64'(div_start_o), 64'd0);
        chk("tmo_we",      64'(hilo_we_o),   64'd0);
        @(posedge clk); #1;
        aluop = EXE_DIVU_OP; reg1 = 32'd50; reg2 = 32'd5;
        #1;
        chk("tmo_abort1_pulse", 64'(timeout_o),  64'd0);
        chk("tmo_abort1_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #2;
        chk("tmo_abort2_stall", 64'(stallreq_o), 64'd0);

        // back-to-back, second one divides by zero
        run_div("divu_50_5", EXE_DIVU_OP, 32'd50, 32'd5, 3, 32'd0, 32'd10, 1'b0);
        run_div("divu_7_0",  EXE_DIVU_OP, 32'd7,  32'd0, 2, 32'd0, 32'd0,  1'b0);

        // reset in the middle of BUSY
        @(posedge clk); #1;
        issue(EXE_DIVU_OP, 32'd1000, 32'd7, 20, 1'b0);
        @(posedge clk); #1;
        aluop = EXE_NOP_OP;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk_all_zero("midrst");
        run_div("divu_8_2", EXE_DIVU_OP, 32'd8, 32'd2, 3, 32'd0, 32'd4, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty",     64'(sb_q.size()), 64'd0);
        chk("timeout_cnt",  64'(n_timeout),   64'd1);
        chk("annul_cnt",    64'(n_annul),     64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got sim still running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum cycles in BUSY waiting for the divider's ready before abort.
REQ-002 Parameter ABORT_CYCLES, default 2: cycles spent in ABORT with start and annul low before returning to IDLE.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 aluop_i  in  8  EX-stage operation code; DIV and DIVU codes are defined in defines.v.
REQ-006 reg1_i  in  32  dividend operand.
REQ-007 reg2_i  in  32  divisor operand.
REQ-008 flush_i  in  1  pipeline flush (exception or redirect).
REQ-009 div_ready_i  in  1  divider result-ready.
REQ-010 div_result_i  in  64  divider result: {remainder, quotient}.
REQ-011 div_start_o  out  1  divider start; 1 = start, 0 = stop.
REQ-012 div_annul_o  out  1  divider cancel.
REQ-013 signed_div_o  out  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-014 div_opdata1_o / div_opdata2_o  out  32 each  operands held to the divider.
REQ-015 stallreq_o  out  1  pipeline stall request.
REQ-016 hilo_we_o  out  1  HI/LO write enable, one-cycle pulse.
REQ-017 hi_o / lo_o  out  32 each  remainder / quotient to HI/LO.
REQ-018 timeout_o  out  1  one-cycle pulse on watchdog abort.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, BUSY, DONE and ABORT, with encodings in defines.v.
REQ-020 IDLE: when aluop_i is DIV/DIVU and flush_i=0, stallreq_o=1 combinationally, and the FSM latches reg1_i, reg2_i and signedness and moves to BUSY at the next edge.
REQ-021 BUSY: div_start_o=1; operands and signed_div_o come from the latched registers and stay constant for the whole of BUSY; stallreq_o=1; the watchdog counter increments each cycle.
REQ-022 BUSY with div_ready_i=1 and flush_i=0: latch div_result_i and move to DONE.
REQ-023 DONE, lasting 1 cycle: div_start_o=0; hilo_we_o=1 unless flush_i=1; hi_o=latched[63:32], lo_o=latched[31:0]; stallreq_o=0; next state IDLE.
REQ-024 BUSY with flush_i=1: div_annul_o=1 and div_start_o=0 in that cycle; no HI/LO write; move to ABORT. Flush takes priority over a simultaneous div_ready_i.
REQ-025 Watchdog reaching TIMEOUT in BUSY: same outputs as REQ-024, plus timeout_o=1 for one cycle.
REQ-026 ABORT: div_start_o=0, div_annul_o=0, stallreq_o=0 for ABORT_CYCLES cycles, then IDLE. This lets the divider leave its end state so a stale ready is never accepted.
REQ-027 div_ready_i SHALL be ignored in IDLE and ABORT.
REQ-028 A DIV/DIVU in IDLE during the cycle right after DONE SHALL start a new operation; no bubble beyond the IDLE cycle is required.
REQ-029 Divide-by-zero is not special-cased: whatever the divider returns is written (expected 0/0).
REQ-030 div_start_o, div_annul_o, stallreq_o and hilo_we_o SHALL be decoded from state plus current inputs; data outputs SHALL be registered.

Reset
REQ-031 On rst=1 at a clock edge:
- state=IDLE and watchdog=0;
- operand and result registers are cleared to 0;
- every output is 0 in the following cycle.
REQ-032 rst during BUSY SHALL abandon the operation without asserting div_annul_o; the divider is reset by the same rst.

Structure
REQ-033 ALUOP codes for DIV/DIVU, the state encodings and the divider start/stop and ready/not-ready constants belong in defines.v.
REQ-034 div_ctrl SHALL contain no sub-module. Its top-level integration pairs it with the existing multi-cycle divider in EX.

Verification
REQ-035 DIVU 100/7 -> hi_o=2, lo_o=14, single hilo_we_o pulse; stallreq_o high from the IDLE detect until DONE.
REQ-036 DIV 0xFFFFFFF9/2 (i.e. -7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, signed_div_o=1 throughout BUSY.
REQ-037 flush_i in the 10th BUSY cycle -> div_annul_o high for 1 cycle, no hilo_we_o, 2 ABORT cycles, then a following DIVU 9/3 returns lo=3, hi=0.
REQ-038 div_ready_i held low with TIMEOUT=40 -> timeout_o pulses in BUSY cycle 40, no write, FSM reaches IDLE after ABORT.
REQ-039 Back-to-back DIVU 50/5 then DIVU 7/0 -> first write lo=10, hi=0; second write lo=0, hi=0; operands stable across each BUSY.
REQ-040 rst asserted mid-BUSY -> all outputs 0 the next cycle, no hilo_we_o; a subsequent DIVU 8/2 returns lo=4.
